// File: rtl/button_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters.
// Reads return one cycle after acceptance with a strobe routed to the issuing port.
module button_onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // port A
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  // port B
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  // RAM access port
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t prio;
  logic  rv_a, rv_b;
  logic  req_a, req_b;
  logic  grant_a, grant_b;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        grant_a = (prio == PRIO_A);
        grant_b = (prio == PRIO_B);
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign a_waitrequest = ~grant_a;
  assign b_waitrequest = ~grant_b;

  // With no grant the RAM bus idles on port A's fields; chipselect keeps them inert.
  assign mem_address    = grant_b ? b_address    : a_address;
  assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
  assign mem_writedata  = grant_b ? b_writedata  : a_writedata;
  assign mem_chipselect = grant_a | grant_b;
  assign mem_write      = (grant_a & a_write) | (grant_b & b_write);
  assign mem_clken      = 1'b1;

  // NOTE: state registers use non-blocking assignments; reset here is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PRIO_A;
      rv_a <= 1'b0;
      rv_b <= 1'b0;
    end else begin
      // Only contention moves the pointer, and it always lands on the loser.
      if (req_a && req_b) prio <= grant_a ? PRIO_B : PRIO_A;
      rv_a <= grant_a & a_read & ~a_write;
      rv_b <= grant_b & b_read & ~b_write;
    end
  end

  // Gating with reset drops the return of a read accepted just before reset asserts.
  assign a_readdatavalid = rv_a & ~reset;
  assign b_readdatavalid = rv_b & ~reset;
  assign a_readdata      = a_readdatavalid ? mem_readdata : '0;
  assign b_readdata      = b_readdatavalid ? mem_readdata : '0;

endmodule
